// File: rtl/uart_packet_rx_if.sv
// rtl/uart_packet_rx_if.sv - serial line in, assembled element packet and strobes out
interface uart_packet_rx_if;
  logic        rx_in;
  logic [39:0] packet;
  logic        dataReceived;
  logic        frame_err;

  modport master (
    input  rx_in,
    output packet,
    output dataReceived,
    output frame_err
  );

  modport slave (
    output rx_in,
    input  packet,
    input  dataReceived,
    input  frame_err
  );
endinterface

// File: rtl/uart_packet_rx.sv
// rtl/uart_packet_rx.sv - 8N1 UART receiver assembling 5-byte element packets
// Define PKT_TIMEOUT_EN to abort a partial packet after an idle gap of TIMEOUT_BITS bit periods.
module uart_packet_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
`ifdef PKT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_BITS = 20
`endif
) (
  input logic              clk50,
  input logic              rst_n,
  uart_packet_rx_if.master bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       sync_q, sync_d;
  logic             rx_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitn_q, bitn_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic [0:4][7:0]  asm_q, asm_d;
  logic [39:0]      packet_q, packet_d;
  logic             drv_q, drv_d;
  logic             ferr_q, ferr_d;
  logic             timeout;

  assign rx_s = sync_q[1];

`ifdef PKT_TIMEOUT_EN
  localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             gap_run;

  // Gap counts only while a partial packet waits on an idle line; a start edge drops gap_run.
  always_comb begin
    gap_run = (state_q == IDLE) && (idx_q != 3'd0) && rx_s;
    timeout = gap_run && (gap_q == GAP_W'(GAP_LIMIT - 1));
    gap_d   = '0;
    if (gap_run && !timeout) gap_d = gap_q + GAP_W'(1);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    sync_d   = {sync_q[0], bus.rx_in};
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitn_d   = bitn_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    packet_d = packet_q;
    drv_d    = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bitn_d = 3'd0;
        if (!rx_s) state_d = START;
        if (timeout) begin
          idx_d = 3'd0;
          asm_d = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            asm_d[idx_q] = shift_q;
            if (idx_q == 3'd4) begin
              // Publish the whole packet at once, including the byte that completes it.
              packet_d = {asm_q[0], asm_q[1], asm_q[2], asm_q[3], shift_q};
              drv_d    = 1'b1;
              idx_d    = 3'd0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            ferr_d = 1'b1;
            idx_d  = 3'd0;
            asm_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitn_q   <= 3'd0;
      shift_q  <= 8'd0;
      idx_q    <= 3'd0;
      asm_q    <= '0;
      packet_q <= 40'd0;
      drv_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitn_q   <= bitn_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      packet_q <= packet_d;
      drv_q    <= drv_d;
      ferr_q   <= ferr_d;
    end
  end

  assign bus.packet       = packet_q;
  assign bus.dataReceived = drv_q;
  assign bus.frame_err    = ferr_q;

endmodule
